// File: rtl/leaf_issue_unit_pkg.sv
// Shared traversal types: ray/triangle identifiers and the request structs
// exchanged between the leaf issue unit, the list unit and the short stack.
package leaf_issue_pkg;

    localparam int CNT_W = 6;

    typedef logic [31:0]      float_t;
    typedef logic [15:0]      triID_t;
    typedef logic [7:0]       rayID_t;
    typedef logic [CNT_W-1:0] tri_cnt_t;

    typedef struct packed {
        rayID_t rayID;
        float_t t_min;
    } ray_info_t;

    typedef struct packed {
        rayID_t rayID;
        float_t t_max_leaf;
    } trav_to_list_t;

    typedef struct packed {
        ray_info_t ray_info;
        float_t    t_max_leaf;
    } list_to_ss_t;

    typedef struct packed {
        ray_info_t ray_info;
        triID_t    tri_base;
        tri_cnt_t  tri_cnt;
        float_t    t_max_leaf;
    } leaf_req_t;

    typedef struct packed {
        ray_info_t ray_info;
        triID_t    triID;
        logic      is_last;
    } tri_req_t;

endpackage

// File: rtl/leaf_issue_unit_counter.sv
// Up-counter with synchronous clear (priority over increment) and async reset.
module leaf_issue_unit_counter #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    // NOTE: sequential state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/leaf_issue_unit.sv
// Expands one leaf request into a t_max_leaf write followed by one triangle
// request per triangle, or a single miss toward the short stack for empty leaves.
module leaf_issue_unit #(
    parameter int CNT_W = leaf_issue_pkg::CNT_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          leaf_valid,
    input  leaf_issue_pkg::leaf_req_t     leaf_data,
    output logic                          leaf_stall,
    output logic                          trav_to_list_valid,
    output leaf_issue_pkg::trav_to_list_t trav_to_list_data,
    input  logic                          trav_to_list_stall,
    output logic                          tri_req_valid,
    output leaf_issue_pkg::tri_req_t      tri_req_data,
    input  logic                          tri_req_stall,
    output logic                          empty_to_ss_valid,
    output leaf_issue_pkg::list_to_ss_t   empty_to_ss_data,
    input  logic                          empty_to_ss_stall
);

    import leaf_issue_pkg::*;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] SEND_TMAX = 2'd1;
    localparam logic [1:0] ISSUE     = 2'd2;
    localparam logic [1:0] SEND_MISS = 2'd3;

    logic [1:0]       state;
    logic [1:0]       state_nx;
    leaf_req_t        leaf_q;
    logic [CNT_W-1:0] idx;
    logic [CNT_W-1:0] last_idx;
    logic             leaf_accept;
    logic             tri_fire;
    logic             is_last;

    assign leaf_accept = (state == IDLE) && leaf_valid;
    assign tri_fire    = (state == ISSUE) && !tri_req_stall;
    assign last_idx    = CNT_W'(leaf_q.tri_cnt) - CNT_W'(1);
    assign is_last     = (idx == last_idx);

    leaf_issue_unit_counter #(.W(CNT_W)) u_idx (
        .clk   (clk),
        .rst   (rst),
        .clr   (leaf_accept),
        .inc   (tri_fire),
        .count (idx)
    );

    // NOTE: state_nx gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (leaf_valid)
                           state_nx = (leaf_data.tri_cnt == '0) ? SEND_MISS : SEND_TMAX;
            SEND_TMAX: if (!trav_to_list_stall) state_nx = ISSUE;
            ISSUE:     if (tri_fire && is_last) state_nx = IDLE;
            SEND_MISS: if (!empty_to_ss_stall) state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            leaf_q <= '0;
        end else begin
            state <= state_nx;
            if (leaf_accept) begin
                leaf_q <= leaf_data;
            end
        end
    end

    // Every output is decoded from the state register or the latched leaf,
    // so no stall input reaches leaf_stall combinationally.
    assign leaf_stall         = (state != IDLE);
    assign trav_to_list_valid = (state == SEND_TMAX);
    assign tri_req_valid      = (state == ISSUE);
    assign empty_to_ss_valid  = (state == SEND_MISS);

    assign trav_to_list_data = '{rayID: leaf_q.ray_info.rayID, t_max_leaf: leaf_q.t_max_leaf};
    assign tri_req_data      = '{ray_info: leaf_q.ray_info,
                                 triID:    leaf_q.tri_base + triID_t'(idx),
                                 is_last:  is_last};
    assign empty_to_ss_data  = '{ray_info: leaf_q.ray_info, t_max_leaf: leaf_q.t_max_leaf};

endmodule

// File: tb/tb_leaf_issue_unit.sv
// Scenario bench for leaf_issue_unit: a negedge monitor pops per-port
// expectation queues; each scenario task adds its own inline checks.
module tb_leaf_issue_unit;

    import leaf_issue_pkg::*;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          leaf_valid = 1'b0;
    leaf_req_t     leaf_data = '0;
    logic          leaf_stall;
    logic          trav_to_list_valid;
    trav_to_list_t trav_to_list_data;
    logic          trav_to_list_stall = 1'b0;
    logic          tri_req_valid;
    tri_req_t      tri_req_data;
    logic          tri_req_stall = 1'b0;
    logic          empty_to_ss_valid;
    list_to_ss_t   empty_to_ss_data;
    logic          empty_to_ss_stall = 1'b0;

    int errors = 0;
    int checks = 0;
    int n_tmax = 0;
    int n_tri  = 0;
    int n_last = 0;
    int n_miss = 0;

    trav_to_list_t tmax_q[$];
    tri_req_t      tri_q[$];
    list_to_ss_t   miss_q[$];

    always #5 clk = ~clk;

    leaf_issue_unit dut (
        .clk                (clk),
        .rst                (rst),
        .leaf_valid         (leaf_valid),
        .leaf_data          (leaf_data),
        .leaf_stall         (leaf_stall),
        .trav_to_list_valid (trav_to_list_valid),
        .trav_to_list_data  (trav_to_list_data),
        .trav_to_list_stall (trav_to_list_stall),
        .tri_req_valid      (tri_req_valid),
        .tri_req_data       (tri_req_data),
        .tri_req_stall      (tri_req_stall),
        .empty_to_ss_valid  (empty_to_ss_valid),
        .empty_to_ss_data   (empty_to_ss_data),
        .empty_to_ss_stall  (empty_to_ss_stall)
    );

    // Transfer monitor: a transfer seen here completes at the next posedge.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if ((32'(trav_to_list_valid) + 32'(tri_req_valid) + 32'(empty_to_ss_valid)) > 1) begin
                errors++;
                $display("FAIL onehot_valid: got tmax=%b tri=%b miss=%b, want at most one",
                         trav_to_list_valid, tri_req_valid, empty_to_ss_valid);
            end
            if (trav_to_list_valid && !trav_to_list_stall) begin
                trav_to_list_t e;
                n_tmax++;
                checks++;
                if (tmax_q.size() == 0) begin
                    errors++;
                    $display("FAIL tmax_unexpected: got %h, want no transfer", trav_to_list_data);
                end else begin
                    e = tmax_q.pop_front();
                    if (trav_to_list_data !== e) begin
                        errors++;
                        $display("FAIL tmax_data: got %h, want %h", trav_to_list_data, e);
                    end
                end
            end
            if (tri_req_valid && !tri_req_stall) begin
                tri_req_t e;
                n_tri++;
                if (tri_req_data.is_last) n_last++;
                checks++;
                if (tri_q.size() == 0) begin
                    errors++;
                    $display("FAIL tri_unexpected: got %h, want no transfer", tri_req_data);
                end else begin
                    e = tri_q.pop_front();
                    if (tri_req_data !== e) begin
                        errors++;
                        $display("FAIL tri_data: got id=%h last=%b, want id=%h last=%b",
                                 tri_req_data.triID, tri_req_data.is_last, e.triID, e.is_last);
                    end
                end
            end
            if (empty_to_ss_valid && !empty_to_ss_stall) begin
                list_to_ss_t e;
                n_miss++;
                checks++;
                if (miss_q.size() == 0) begin
                    errors++;
                    $display("FAIL miss_unexpected: got %h, want no transfer", empty_to_ss_data);
                end else begin
                    e = miss_q.pop_front();
                    if (empty_to_ss_data !== e) begin
                        errors++;
                        $display("FAIL miss_data: got %h, want %h", empty_to_ss_data, e);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_leaf(input ray_info_t ri, input triID_t base, input int cnt, input float_t tmax);
        int n = 0;
        while (leaf_stall && n < 50) begin
            step();
            n++;
        end
        checks++;
        if (n >= 50) begin
            errors++;
            $display("FAIL leaf_accept_timeout: got leaf_stall=%b, want 0", leaf_stall);
        end
        leaf_valid = 1'b1;
        leaf_data  = '{ray_info: ri, tri_base: base, tri_cnt: tri_cnt_t'(cnt), t_max_leaf: tmax};
        if (cnt == 0) begin
            miss_q.push_back('{ray_info: ri, t_max_leaf: tmax});
        end else begin
            tmax_q.push_back('{rayID: ri.rayID, t_max_leaf: tmax});
            for (int i = 0; i < cnt; i++) begin
                triID_t id;
                id = base + triID_t'(i);
                tri_q.push_back('{ray_info: ri, triID: id, is_last: (i == cnt - 1)});
            end
        end
        step();
        leaf_valid = 1'b0;
        leaf_data  = '1;
    endtask

    task automatic wait_idle(input int budget, input bit toggle);
        int n = 0;
        while ((tmax_q.size() != 0 || tri_q.size() != 0 || miss_q.size() != 0 || leaf_stall)
               && n < budget) begin
            if (toggle) tri_req_stall = ~tri_req_stall;
            step();
            n++;
        end
        tri_req_stall = 1'b0;
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL idle_timeout: got pending tmax=%0d tri=%0d miss=%0d, want 0",
                     tmax_q.size(), tri_q.size(), miss_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        checks++;
        if ({leaf_stall, trav_to_list_valid, tri_req_valid, empty_to_ss_valid} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: got stall/valids=%b, want 0000",
                     {leaf_stall, trav_to_list_valid, tri_req_valid, empty_to_ss_valid});
        end
        checks++;
        if (trav_to_list_data !== '0 || empty_to_ss_data !== '0) begin
            errors++;
            $display("FAIL reset_leaf_reg: got %h / %h, want 0", trav_to_list_data, empty_to_ss_data);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        float_t tmax = 32'h4120_0000;
        ray_info_t ri = '{rayID: 8'd7, t_min: 32'h3f80_0000};
        trav_to_list_t et = '{rayID: 8'd7, t_max_leaf: 32'h4120_0000};
        send_leaf(ri, 16'd100, 3, tmax);
        @(negedge clk);
        checks++;
        if (!trav_to_list_valid || tri_req_valid || trav_to_list_data !== et) begin
            errors++;
            $display("FAIL basic_tmax_cycle: got v=%b tri=%b d=%h, want v=1 tri=0 d=%h",
                     trav_to_list_valid, tri_req_valid, trav_to_list_data, et);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (!tri_req_valid || tri_req_data.triID !== 16'(100 + i) || tri_req_data.is_last !== (i == 2)) begin
                errors++;
                $display("FAIL basic_tri_cycle%0d: got v=%b id=%0d last=%b, want v=1 id=%0d last=%b",
                         i, tri_req_valid, tri_req_data.triID, tri_req_data.is_last, 100 + i, (i == 2));
            end
        end
        @(negedge clk);
        checks++;
        if (leaf_stall !== 1'b0 || tri_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_idle_cycle: got stall=%b tri=%b, want 0 0", leaf_stall, tri_req_valid);
        end
        wait_idle(20, 1'b0);
    endtask

    task automatic test_empty();
        int b_tmax = n_tmax;
        int b_tri  = n_tri;
        int b_miss = n_miss;
        send_leaf('{rayID: 8'd42, t_min: 32'h0000_1234}, 16'd555, 0, 32'h4080_0000);
        wait_idle(20, 1'b0);
        checks++;
        if (n_miss - b_miss != 1 || n_tmax != b_tmax || n_tri != b_tri) begin
            errors++;
            $display("FAIL empty_counts: got miss=%0d tmax=%0d tri=%0d, want 1 0 0",
                     n_miss - b_miss, n_tmax - b_tmax, n_tri - b_tri);
        end
    endtask

    task automatic test_list_stall();
        trav_to_list_t et = '{rayID: 8'd9, t_max_leaf: 32'h4200_0000};
        trav_to_list_stall = 1'b1;
        send_leaf('{rayID: 8'd9, t_min: 32'h0}, 16'd20, 2, 32'h4200_0000);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (tri_req_valid !== 1'b0 || trav_to_list_valid !== 1'b1 || trav_to_list_data !== et) begin
                errors++;
                $display("FAIL list_stall_hold%0d: got tri=%b tmax=%b d=%h, want 0 1 %h",
                         i, tri_req_valid, trav_to_list_valid, trav_to_list_data, et);
            end
        end
        step();
        trav_to_list_stall = 1'b0;
        wait_idle(20, 1'b0);
    endtask

    task automatic test_tri_stall_toggle();
        int b_tri  = n_tri;
        int b_last = n_last;
        send_leaf('{rayID: 8'd3, t_min: 32'h0}, 16'd200, 5, 32'h4300_0000);
        wait_idle(100, 1'b1);
        checks++;
        if (n_tri - b_tri != 5 || n_last - b_last != 1) begin
            errors++;
            $display("FAIL toggle_counts: got tri=%0d last=%0d, want 5 1", n_tri - b_tri, n_last - b_last);
        end
    endtask

    task automatic test_wrap();
        int b_tri = n_tri;
        send_leaf('{rayID: 8'd11, t_min: 32'h0}, 16'hFFFF, 2, 32'h4400_0000);
        wait_idle(20, 1'b0);
        checks++;
        if (n_tri - b_tri != 2) begin
            errors++;
            $display("FAIL wrap_count: got %0d, want 2", n_tri - b_tri);
        end
    endtask

    task automatic test_reset_mid();
        int b_tri = n_tri;
        int n = 0;
        send_leaf('{rayID: 8'd5, t_min: 32'h0}, 16'd300, 4, 32'h4500_0000);
        while (n_tri - b_tri < 2 && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (n_tri - b_tri != 2 || tri_req_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_pre: got tri=%0d v=%b, want 2 1", n_tri - b_tri, tri_req_valid);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({leaf_stall, trav_to_list_valid, tri_req_valid, empty_to_ss_valid} !== 4'b0000
            || tri_req_data.triID !== 16'd0) begin
            errors++;
            $display("FAIL reset_mid_async: got stall/valids=%b id=%h, want 0000 0",
                     {leaf_stall, trav_to_list_valid, tri_req_valid, empty_to_ss_valid},
                     tri_req_data.triID);
        end
        tmax_q.delete();
        tri_q.delete();
        miss_q.delete();
        step();
        rst = 1'b0;
        checks++;
        if (leaf_stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_ready: got leaf_stall=%b, want 0", leaf_stall);
        end
        b_tri = n_tri;
        send_leaf('{rayID: 8'd6, t_min: 32'h0}, 16'd400, 2, 32'h4600_0000);
        wait_idle(20, 1'b0);
        checks++;
        if (n_tri - b_tri != 2) begin
            errors++;
            $display("FAIL reset_mid_next: got tri=%0d, want 2", n_tri - b_tri);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_empty();
        test_list_stall();
        test_tri_stall_toggle();
        test_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/leaf_issue_unit.md
LEAF_ISSUE_UNIT -- requirements
Module: leaf_issue_unit

Interface
REQ-001 Parameter CNT_W, default 6: width of the per-leaf triangle count field; a leaf holds 0..2^CNT_W-1 triangles.
REQ-002 clk  input  1  single clock for the block.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 leaf_valid  input  1  a leaf request is presented.
REQ-005 leaf_data  input  leaf_req_t  fields: ray_info (ray_info_t), tri_base (triID_t), tri_cnt (CNT_W bits), t_max_leaf (float_t).
REQ-006 leaf_stall  output  1  request not accepted this cycle.
REQ-007 trav_to_list_valid  output  1  t_max_leaf write toward the list unit.
REQ-008 trav_to_list_data  output  trav_to_list_t  fields: rayID, t_max_leaf.
REQ-009 trav_to_list_stall  input  1  list unit refuses the write.
REQ-010 tri_req_valid  output  1  one triangle test request toward intersection.
REQ-011 tri_req_data  output  tri_req_t  fields: ray_info, triID, is_last.
REQ-012 tri_req_stall  input  1  intersection refuses the request.
REQ-013 empty_to_ss_valid  output  1  empty-leaf miss toward the short stack.
REQ-014 empty_to_ss_data  output  list_to_ss_t  fields: ray_info, t_max_leaf.
REQ-015 empty_to_ss_stall  input  1  short stack refuses the miss.

Function
REQ-016 Handshake on every port: transfer occurs in a cycle with valid=1 and stall=0; while stalled, a sender holds valid and data unchanged.
REQ-017 FSM states: IDLE, SEND_TMAX, ISSUE, SEND_MISS.
REQ-018 leaf_stall = 1 in every state except IDLE; leaf_stall = 0 in IDLE.
REQ-019 IDLE: on leaf transfer, latch leaf_data into a leaf register and clear the triangle index idx to 0.
REQ-020 From IDLE on transfer: go to SEND_MISS if tri_cnt==0, otherwise go to SEND_TMAX.
REQ-021 SEND_TMAX: drive trav_to_list_valid=1 with the latched rayID and t_max_leaf.
REQ-022 SEND_TMAX: on transfer, go to ISSUE.
REQ-023 Ordering: no triangle request for a leaf is issued before that leaf's t_max_leaf write has transferred, so the list read triggered by is_last always sees the current leaf bound.
REQ-024 ISSUE: drive tri_req_valid=1 with triID = tri_base + idx, computed modulo 2^$bits(triID_t) (wraps, no error).
REQ-025 ISSUE: is_last = 1 exactly when idx == tri_cnt-1.
REQ-026 ISSUE: on each transfer, increment idx; on the transfer with is_last=1, return to IDLE.
REQ-027 Throughput: one triangle per cycle when unstalled; a leaf of N>0 triangles costs N+1 unstalled cycles after acceptance, followed by 1 cycle in IDLE.
REQ-028 SEND_MISS: drive empty_to_ss_valid=1 with the latched ray_info and t_max_leaf; no t_max_leaf write and no triangle request are made for that leaf.
REQ-029 SEND_MISS: on transfer, return to IDLE.
REQ-030 Latency: a leaf accepted at edge N drives its first output valid in cycle N+1.
REQ-031 All outputs come from registered state or from the latched leaf register; there is no combinational path from any stall input to leaf_stall.
REQ-032 At most one of trav_to_list_valid, tri_req_valid, empty_to_ss_valid is 1 in any cycle.

Reset
REQ-033 rst asserted, including mid-leaf: FSM goes to IDLE, idx=0, leaf register=0, all valid outputs=0, leaf_stall=0; the in-flight leaf is dropped without completion.
REQ-034 The first leaf can be accepted in the first cycle after rst deasserts.

Structure
REQ-035 leaf_req_t and tri_req_t are added to the shared package beside trav_to_list_t and list_to_ss_t; CNT_W lives there as a constant.
REQ-036 The block is a single module; idx uses the codebase counter sub-module with clr on leaf accept and inc on triangle transfer.

Verification
REQ-037 Scenario: tri_cnt=3, tri_base=100, rayID=7, no stalls -> one trav_to_list {7,t_max} in cycle N+1; triIDs 100, 101, 102 in N+2..N+4 with is_last only on 102; leaf_stall drops in N+5.
REQ-038 Scenario: tri_cnt=0 -> exactly one empty_to_ss transfer carrying the leaf's ray_info and t_max_leaf; zero trav_to_list and zero tri_req transfers.
REQ-039 Scenario: trav_to_list_stall high for 4 cycles -> no tri_req_valid during those 4 cycles; the trav_to_list data is held stable throughout.
REQ-040 Scenario: tri_req_stall toggling on alternate cycles with tri_cnt=5 -> exactly 5 transfers, consecutive triIDs, exactly one is_last.
REQ-041 Scenario: tri_base=2^$bits(triID_t)-1, tri_cnt=2 -> triIDs max, then 0.
REQ-042 Scenario: rst pulsed during ISSUE after 2 of 4 triangles -> all valids go to 0 asynchronously; the next leaf completes normally.
